// File: rtl/poly_sequencer.sv
// Stream-driven sequencer for the shared-ALU polynomial datapath: loads A, B, C, X, then runs
// five ALU cycles computing R = A + B*X + C*X^2. Optional evaluation counter: POLY_SEQ_STATS_EN.
module poly_sequencer #(
    parameter int DATA_W      = 8,
    parameter int RES_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] dp_data_in,
    output logic              ld_a,
    output logic              ld_b,
    output logic              ld_c,
    output logic              ld_x,
    output logic              ld_r,
    output logic              ld_alu_out,
    output logic [1:0]        alu_select_a,
    output logic [1:0]        alu_select_b,
    output logic              alu_op,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_dropped,
    output logic [15:0]       eval_count,
    output logic [3:0]        fsm_state
);

    // Handshakes: a transfer occurs on any rising edge where valid and ready are both high;
    // valid never depends on ready, and ready may depend on valid only through state.
    typedef enum logic [3:0] {
        LOAD_A, LOAD_B, LOAD_C, LOAD_X, CYC0, CYC1, CYC2, CYC3, CYC4, DONE
    } state_t;

    localparam int TW = (RES_TIMEOUT > 1) ? $clog2(RES_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((RES_TIMEOUT > 0) ? RES_TIMEOUT - 1 : 0);

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic          res_drop;

    // Ready wins over a timeout landing in the same cycle.
    assign res_drop = (RES_TIMEOUT != 0) && (state == DONE) && !res_ready && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= LOAD_A;
            tmo_cnt <= '0;
        end else begin
            case (state)
                LOAD_A: if (in_valid) state <= LOAD_B;
                LOAD_B: if (in_valid) state <= LOAD_C;
                LOAD_C: if (in_valid) state <= LOAD_X;
                LOAD_X: if (in_valid) state <= CYC0;
                CYC0:   state <= CYC1;
                CYC1:   state <= CYC2;
                CYC2:   state <= CYC3;
                CYC3:   state <= CYC4;
                CYC4:   state <= DONE;
                DONE:   if (res_ready || res_drop) state <= LOAD_A;
                default: state <= LOAD_A;
            endcase
            if (state == DONE && !res_ready && !res_drop) tmo_cnt <= tmo_cnt + 1'b1;
            else                                           tmo_cnt <= '0;
        end
    end

    always_comb begin
        in_ready     = 1'b0;
        ld_a         = 1'b0;
        ld_b         = 1'b0;
        ld_c         = 1'b0;
        ld_x         = 1'b0;
        ld_r         = 1'b0;
        ld_alu_out   = 1'b0;
        alu_select_a = 2'd0;
        alu_select_b = 2'd0;
        alu_op       = 1'b0;
        busy         = 1'b0;
        res_valid    = 1'b0;
        res_dropped  = 1'b0;
        dp_data_in   = resetn ? in_data : '0;
        fsm_state    = resetn ? state : 4'd0;
        if (resetn) begin
            case (state)
                LOAD_A: begin in_ready = 1'b1; ld_a = in_valid; end
                LOAD_B: begin in_ready = 1'b1; ld_b = in_valid; end
                LOAD_C: begin in_ready = 1'b1; ld_c = in_valid; end
                LOAD_X: begin in_ready = 1'b1; ld_x = in_valid; end
                CYC0: begin
                    busy = 1'b1; ld_alu_out = 1'b1; ld_b = 1'b1;
                    alu_select_a = 2'd1; alu_select_b = 2'd3; alu_op = 1'b1;
                end
                CYC1: begin
                    busy = 1'b1; ld_alu_out = 1'b1; ld_a = 1'b1;
                    alu_select_a = 2'd0; alu_select_b = 2'd1; alu_op = 1'b0;
                end
                CYC2: begin
                    busy = 1'b1; ld_alu_out = 1'b1; ld_b = 1'b1;
                    alu_select_a = 2'd3; alu_select_b = 2'd3; alu_op = 1'b1;
                end
                CYC3: begin
                    busy = 1'b1; ld_alu_out = 1'b1; ld_b = 1'b1;
                    alu_select_a = 2'd2; alu_select_b = 2'd1; alu_op = 1'b1;
                end
                CYC4: begin
                    busy = 1'b1; ld_alu_out = 1'b1; ld_r = 1'b1;
                    alu_select_a = 2'd0; alu_select_b = 2'd1; alu_op = 1'b0;
                end
                DONE: begin
                    res_valid   = 1'b1;
                    res_dropped = res_drop;
                end
                default: ;
            endcase
        end
    end

`ifdef POLY_SEQ_STATS_EN
    logic [15:0] eval_q;

    always_ff @(posedge clk) begin
        if (!resetn)                            eval_q <= '0;
        else if (state == DONE && res_ready)    eval_q <= eval_q + 16'd1;
    end

    assign eval_count = resetn ? eval_q : 16'd0;
`else
    assign eval_count = 16'd0;
`endif

endmodule

// File: tb/tb_poly_sequencer.sv
// Bench for poly_sequencer: a behavioural datapath plant plus an arithmetic reference model;
// a second instance with a result timeout of 4 runs in lockstep on the same stimulus.
module tb_poly_sequencer;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        res_ready;

    logic        in_ready, ld_a, ld_b, ld_c, ld_x, ld_r, ld_alu_out, alu_op, busy, res_valid, res_dropped;
    logic [7:0]  dp_data_in;
    logic [1:0]  alu_select_a, alu_select_b;
    logic [15:0] eval_count;
    logic [3:0]  fsm_state;

    logic        t_in_ready, t_ld_a, t_ld_b, t_ld_c, t_ld_x, t_ld_r, t_ld_alu_out, t_alu_op, t_busy;
    logic        t_res_valid, t_res_dropped;
    logic [7:0]  t_dp_data_in;
    logic [1:0]  t_alu_select_a, t_alu_select_b;
    logic [15:0] t_eval_count;
    logic [3:0]  t_fsm_state;

    logic [4:0]  ld_vec;
    assign ld_vec = {ld_a, ld_b, ld_c, ld_x, ld_r};

    poly_sequencer #(.DATA_W(8), .RES_TIMEOUT(0)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dp_data_in(dp_data_in), .ld_a(ld_a), .ld_b(ld_b), .ld_c(ld_c), .ld_x(ld_x), .ld_r(ld_r),
        .ld_alu_out(ld_alu_out), .alu_select_a(alu_select_a), .alu_select_b(alu_select_b),
        .alu_op(alu_op), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_dropped(res_dropped), .eval_count(eval_count), .fsm_state(fsm_state)
    );

    poly_sequencer #(.DATA_W(8), .RES_TIMEOUT(4)) dut_t (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(t_in_ready), .in_data(in_data),
        .dp_data_in(t_dp_data_in), .ld_a(t_ld_a), .ld_b(t_ld_b), .ld_c(t_ld_c), .ld_x(t_ld_x),
        .ld_r(t_ld_r), .ld_alu_out(t_ld_alu_out), .alu_select_a(t_alu_select_a),
        .alu_select_b(t_alu_select_b), .alu_op(t_alu_op), .busy(t_busy), .res_valid(t_res_valid),
        .res_ready(res_ready), .res_dropped(t_res_dropped), .eval_count(t_eval_count),
        .fsm_state(t_fsm_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath plant driven by the sequencer's control outputs
    logic [7:0] ra = 8'd0, rb = 8'd0, rc = 8'd0, rx = 8'd0, rr = 8'd0;
    logic [7:0] opa, opb, alu;

    always_comb begin
        case (alu_select_a)
            2'd0: opa = ra;
            2'd1: opa = rb;
            2'd2: opa = rc;
            default: opa = rx;
        endcase
        case (alu_select_b)
            2'd0: opb = ra;
            2'd1: opb = rb;
            2'd2: opb = rc;
            default: opb = rx;
        endcase
        alu = alu_op ? (opa * opb) : (opa + opb);
    end

    always_ff @(posedge clk) begin
        if (ld_a) ra <= ld_alu_out ? alu : dp_data_in;
        if (ld_b) rb <= ld_alu_out ? alu : dp_data_in;
        if (ld_c) rc <= dp_data_in;
        if (ld_x) rx <= dp_data_in;
        if (ld_r) rr <= alu;
    end

    // Scoreboard
    logic [7:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cnt0  = 0;
    int cnt_t = 0;

    function automatic logic [7:0] ref_poly(input int a, input int b, input int c, input int x);
        int s;
        s = a + b * x + c * x * x;
        return 8'(s);
    endfunction

    function automatic int exp_cnt(input int n);
`ifdef POLY_SEQ_STATS_EN
        return n % 65536;
`else
        return 0 * n;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_coeffs(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                               input logic [7:0] x, input bit toggle, input bit hold);
        logic [7:0] v[4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = x;
        for (int k = 0; k < 4; k++) begin
            if (toggle) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                #1;
                check("idle_ready", 32'(in_ready), 1);
                check("idle_ld", 32'(ld_vec), 0);
                step();
            end
            in_valid = 1'b1;
            in_data  = v[k];
            #1;
            check("acc_ready", 32'(in_ready), 1);
            check("acc_ld", 32'(ld_vec), 32'(5'b10000 >> k));
            check("dp_data_in", 32'(dp_data_in), 32'(v[k]));
            check("t_acc_ready", 32'(t_in_ready), 1);
            step();
        end
        in_valid = hold;
        exp_q.push_back(ref_poly(a, b, c, x));
    endtask

    task automatic compute(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            #1;
            check("cyc_busy", 32'(busy), 1);
            check("cyc_ready", 32'(in_ready), 0);
            check("cyc_res_valid", 32'(res_valid), 0);
            check("cyc_alu_src", 32'(ld_alu_out), 1);
            step();
        end
    endtask

    task automatic finish_result(input int delay);
        logic [7:0] exp;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard_empty: observed 0 expected 1");
            return;
        end
        exp = exp_q.pop_front();
        for (int k = 0; k < delay; k++) begin
            res_ready = 1'b0;
            #1;
            check("wait_res_valid", 32'(res_valid), 1);
            check("wait_result", 32'(rr), 32'(exp));
            check("wait_in_ready", 32'(in_ready), 0);
            check("wait_dropped", 32'(res_dropped), 0);
            check("t_res_valid", 32'(t_res_valid), (k < 4) ? 1 : 0);
            check("t_res_dropped", 32'(t_res_dropped), (k == 3) ? 1 : 0);
            check("t_in_ready", 32'(t_in_ready), (k >= 4) ? 1 : 0);
            step();
        end
        res_ready = 1'b1;
        #1;
        check("res_valid", 32'(res_valid), 1);
        check("result", 32'(rr), 32'(exp));
        check("t_hs_dropped", 32'(t_res_dropped), 0);
        cnt0++;
        if (delay < 4) cnt_t++;
        step();
        res_ready = 1'b0;
        #1;
        check("post_in_ready", 32'(in_ready), 1);
        check("post_busy", 32'(busy), 0);
        check("post_res_valid", 32'(res_valid), 0);
        check("eval_count", 32'(eval_count), exp_cnt(cnt0));
        check("t_eval_count", 32'(t_eval_count), exp_cnt(cnt_t));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         tg;
        int         dly;
        logic [7:0] a, b, c, x;

        resetn = 1'b0; in_valid = 1'b0; in_data = 8'd0; res_ready = 1'b0;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_ld", 32'(ld_vec), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_eval", 32'(eval_count), 0);
        resetn = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 1);
        check("rel_state", 32'(fsm_state), 0);
        step();

        // Held valid: acceptance only in LOAD states, result 6 cycles after X
        send_coeffs(8'd3, 8'd2, 8'd1, 8'd4, 1'b0, 1'b1);
        compute(5);
        finish_result(0);

        // Intermediate truncation
        send_coeffs(8'hFF, 8'h10, 8'h02, 8'h10, 1'b0, 1'b0);
        compute(5);
        finish_result(1);

        // Valid toggling every other cycle
        send_coeffs(8'd1, 8'd1, 8'd1, 8'd3, 1'b1, 1'b0);
        compute(5);
        finish_result(0);

        // Long consumer stall; the timeout instance drops in its 4th DONE cycle
        send_coeffs(8'h5A, 8'h33, 8'hC1, 8'h07, 1'b0, 1'b0);
        compute(5);
        finish_result(20);

        // Reset during CYC2 discards the evaluation in flight
        send_coeffs(8'd9, 8'd8, 8'd7, 8'd6, 1'b0, 1'b0);
        void'(exp_q.pop_back());
        compute(2);
        check("cyc2_busy", 32'(busy), 1);
        resetn = 1'b0;
        #1;
        check("rst_mid_ld", 32'(ld_vec), 0);
        check("rst_mid_busy", 32'(busy), 0);
        step();
        check("rst_next_ld", 32'(ld_vec), 0);
        check("rst_next_busy", 32'(busy), 0);
        check("rst_next_res_valid", 32'(res_valid), 0);
        check("rst_next_eval", 32'(eval_count), 0);
        cnt0 = 0;
        cnt_t = 0;
        resetn = 1'b1;
        #1;
        check("rst_rel_in_ready", 32'(in_ready), 1);
        step();
        send_coeffs(8'd3, 8'd2, 8'd1, 8'd4, 1'b0, 1'b0);
        compute(5);
        finish_result(2);

        // Randomized evaluations
        for (int n = 0; n < 12; n++) begin
            a   = 8'($urandom_range(0, 255));
            b   = 8'($urandom_range(0, 255));
            c   = 8'($urandom_range(0, 255));
            x   = 8'($urandom_range(0, 255));
            tg  = 1'($urandom_range(0, 1));
            dly = $urandom_range(0, 6);
            send_coeffs(a, b, c, x, tg, 1'b0);
            compute(5);
            finish_result(dly);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/poly_sequencer.md
Name: poly_sequencer

Overview:
- Stream-driven controller for the shared-ALU polynomial datapath (registers A/B/C/X, add/mul ALU, result register R).
- Replaces push-button "go" sequencing with a valid/ready coefficient input and a valid/ready result handshake.
- Drives every datapath control input and schedules the five ALU cycles that compute R = A + B·X + C·X² mod 2^DATA_W.
- Sits between an upstream producer (UART/host FIFO) and the datapath. The result data is read directly from the datapath's data_result; this block only qualifies it.

Parameters:
DATA_W, 8, width of the coefficient bus passed through to the datapath.
RES_TIMEOUT, 0, cycles DONE waits for res_ready before dropping the result; 0 = wait forever.

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
in_valid  in  1  coefficient present on in_data
in_ready  out  1  sequencer accepts a coefficient this cycle
in_data  in  DATA_W  coefficient, in order A, B, C, X
dp_data_in  out  DATA_W  to datapath data_in; combinational copy of in_data
ld_a, ld_b, ld_c, ld_x, ld_r  out  1 each  datapath register loads
ld_alu_out  out  1  datapath A/B load source: 1 = ALU, 0 = dp_data_in
alu_select_a, alu_select_b  out  2 each  ALU operand mux (0=A, 1=B, 2=C, 3=X)
alu_op  out  1  0 = add, 1 = multiply
busy  out  1  high in compute states CYC0..CYC4
res_valid  out  1  datapath data_result holds a fresh result
res_ready  in  1  consumer takes the result
res_dropped  out  1  one-cycle pulse on result timeout
eval_count  out  16  completed evaluations (see Optional Feature)

Behaviour:
- States (4-bit): LOAD_A, LOAD_B, LOAD_C, LOAD_X, CYC0, CYC1, CYC2, CYC3, CYC4, DONE.
- Reset: state = LOAD_A, timeout counter = 0, eval_count = 0.
  - All outputs are forced to 0 while resetn is low, including in_ready and all ld_*.
- Output defaults in every state: all ld_* = 0, ld_alu_out = 0, selects = 0, alu_op = 0, busy = 0, res_valid = 0, res_dropped = 0.
- LOAD_k (k = A, B, C, X):
  - in_ready = 1; ld_k = in_valid.
  - On in_valid & in_ready, advance to the next LOAD state; LOAD_X advances to CYC0.
  - With no in_valid, hold the state.
  - Accepting X in cycle t makes CYC0 active in cycle t+1.
- Compute schedule, one cycle each, unconditional advance, busy = 1, ld_alu_out = 1 in all five:
  - CYC0: B <- B*X. sel_a = 1, sel_b = 3, op = 1, ld_b.
  - CYC1: A <- A+B. sel_a = 0, sel_b = 1, op = 0, ld_a.
  - CYC2: B <- X*X. sel_a = 3, sel_b = 3, op = 1, ld_b.
  - CYC3: B <- C*B. sel_a = 2, sel_b = 1, op = 1, ld_b.
  - CYC4: R <- A+B. sel_a = 0, sel_b = 1, op = 0, ld_r; then go to DONE.
- Arithmetic: every ALU result is truncated to DATA_W. The final result is exact mod 2^DATA_W.
- DONE:
  - res_valid = 1, asserted in cycle t+6.
  - in_ready = 0; no ld_* asserted, so data_result stays stable.
  - On res_ready, return to LOAD_A and increment eval_count.
- Timeout (RES_TIMEOUT > 0):
  - The counter counts DONE cycles without res_ready.
  - When the count reaches RES_TIMEOUT, pulse res_dropped for one cycle, return to LOAD_A, and leave eval_count unchanged.
  - If res_ready and the timeout occur in the same cycle, res_ready wins.
  - The counter clears on leaving DONE.
- Input backpressure: in_ready = 0 in CYC0..DONE. A producer holding in_valid high sees no acceptance until LOAD_A.
- Reset mid-operation: takes effect at the next clk edge from any state. Partially loaded coefficients and an in-flight result are discarded; no res_valid follows.
- Back-to-back: a coefficient may be accepted in the cycle immediately after the DONE handshake.

Optional Feature:
- Macro POLY_SEQ_STATS_EN.
- Defined: eval_count is a 16-bit register that wraps 0xFFFF -> 0x0000 and increments once per res_valid & res_ready.
- Undefined: eval_count is tied to 0 and no counter logic is generated.

Test Plan:
- DATA_W = 8. Stream A=3, B=2, C=1, X=4 with in_valid held high -> in_ready high 4 cycles, busy high 5 cycles, res_valid exactly 6 cycles after X is accepted, data_result = 0x1B.
- A=0xFF, B=0x10, C=0x02, X=0x10 -> intermediate truncation, data_result = 0xFF.
- A=1, B=1, C=1, X=3 with in_valid toggled every other cycle -> only valid cycles accepted; data_result = 0x0D.
- res_ready low 20 cycles after res_valid (RES_TIMEOUT = 0) -> res_valid held, in_ready = 0, data_result stable. Raise res_ready -> next cycle in LOAD_A; eval_count increments by 1 when POLY_SEQ_STATS_EN is defined.
- RES_TIMEOUT = 4, res_ready never asserted -> res_dropped pulses in the 4th DONE cycle, then in_ready = 1, eval_count unchanged.
- resetn low during CYC2 -> next cycle all ld_* = 0 and busy = 0. After release, in_ready = 1 in LOAD_A; a fresh A=3, B=2, C=1, X=4 stream yields 0x1B.
